click_count_collector: RTL

- Downstream stage for a bank of click counter channels.
- Each channel presents a 24-bit count result with count_ready, and holds it until acknowledged.
- This block arbitrates the channels round-robin, completes each channel's ready/ack handshake, and emits one 32-bit word {counter_id, count} per result into the host-bound result FIFO through a valid/ready interface.
- It also flags channels that fail to drop count_ready after ack.

---
 rtl/click_count_collector.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/click_count_collector.sv
// Round-robin collector for click counter channels: completes each channel's
// ready/ack handshake and forwards {counter_id, count} words to a valid/ready sink.
module click_count_collector #(
  parameter int NUM_CH      = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [24*NUM_CH-1:0]   ch_count,
  input  logic [8*NUM_CH-1:0]    ch_id,
  input  logic [NUM_CH-1:0]      ch_ready,
  output logic [NUM_CH-1:0]      ch_ack,
  output logic [31:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   err_timeout,
  output logic [3:0]             err_ch,
  input  logic                   err_clear,
  output logic                   dbg_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   ch_ack_q, ch_ack_d;
  logic [31:0]         out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [3:0]          last_grant_q, last_grant_d;
  logic [7:0]          timer_q, timer_d;
  logic                err_timeout_q, err_timeout_d;
  logic [3:0]          err_ch_q, err_ch_d;
  logic [NUM_CH-1:0]   stale_q, stale_d;

  logic [15:0]         eligible;
  logic [4:0]          cand;
  logic                pick_found;
  logic [3:0]          pick_idx;
  logic [NUM_CH-1:0]   pick_mask;
  logic [31:0]         pick_word;
  logic                slot_free;
  logic                cur_ready;
  logic                timeout_evt;

  // Round-robin search starting one past the last grant; stale channels are
  // skipped until their ready has been seen low.
  always_comb begin
    eligible   = 16'(ch_ready & ~stale_q);
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = 5'(last_grant_q) + 5'(k);
      if (cand >= 5'(NUM_CH)) cand = cand - 5'(NUM_CH);
      if (!pick_found && eligible[cand[3:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[3:0];
      end
    end
  end

  always_comb begin
    pick_mask = '0;
    pick_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pick_idx == 4'(i)) begin
        pick_mask[i] = 1'b1;
        pick_word    = {ch_id[8*i +: 8], ch_count[24*i +: 24]};
      end
    end
  end

  // Output handshake: a word transfers on a rising edge where out_valid and
  // out_ready are both high; while out_valid is high and out_ready low the
  // word is held unchanged, and the slot may be refilled in the same cycle
  // that it is drained.
  always_comb begin
    state_d       = state_q;
    ch_ack_d      = ch_ack_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    last_grant_d  = last_grant_q;
    timer_d       = timer_q;
    err_timeout_d = err_timeout_q;
    err_ch_d      = err_ch_q;
    stale_d       = stale_q & ch_ready;
    timeout_evt   = 1'b0;

    slot_free = !out_valid_q || out_ready;
    cur_ready = |(ch_ready & ch_ack_q);

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found && slot_free) begin
          out_data_d   = pick_word;
          out_valid_d  = 1'b1;
          ch_ack_d     = pick_mask;
          last_grant_d = pick_idx;
          timer_d      = '0;
          state_d      = ST_ACK;
        end
      end
      ST_ACK: begin
        // Ack is held, not pulsed: upstream may ignore it for a while.
        if (!cur_ready) begin
          ch_ack_d = '0;
          state_d  = ST_IDLE;
        end else if (timer_q == TMO_LAST) begin
          ch_ack_d    = '0;
          state_d     = ST_IDLE;
          timeout_evt = 1'b1;
          stale_d     = stale_d | ch_ack_q;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (err_clear) begin
      err_timeout_d = 1'b0;
      err_ch_d      = '0;
    end else if (timeout_evt) begin
      err_timeout_d = 1'b1;
    end
    // First offender since the last clear is kept.
    if (timeout_evt && !err_timeout_q) err_ch_d = last_grant_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ch_ack_q      <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      last_grant_q  <= '0;
      timer_q       <= '0;
      err_timeout_q <= 1'b0;
      err_ch_q      <= '0;
      stale_q       <= '0;
    end else begin
      state_q       <= state_d;
      ch_ack_q      <= ch_ack_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      last_grant_q  <= last_grant_d;
      timer_q       <= timer_d;
      err_timeout_q <= err_timeout_d;
      err_ch_q      <= err_ch_d;
      stale_q       <= stale_d;
    end
  end

  assign ch_ack      = ch_ack_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign err_timeout = err_timeout_q;
  assign err_ch      = err_ch_q;
  assign dbg_state   = state_q;

endmodule
